mem_port_arbiter: RTL and testbench

- Shares one slow-memory line port between the I-cache and D-cache miss/write-back interfaces, so both caches run behind a single external memory channel.
- Sits in CHIP between the two cache instances' mem_* ports and the external memory.
- Serves one 128-bit line transaction at a time.
- Round-robin arbitration on simultaneous requests; memory-side outputs are registered at grant.

---
 rtl/mem_port_arbiter_if.sv | 33 +++
 rtl/mem_port_arbiter.sv | 83 ++++++++
 tb/tb_mem_port_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache line ports, the shared memory port and the grant debug bus.
// The slave modport is the arbiter's view; the master modport is the caches and memory around it.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
);
   logic              ic_read, ic_write, ic_ready;
   logic [ADDR_W-1:0] ic_addr;
   logic [DATA_W-1:0] ic_wdata, ic_rdata;
   logic              dc_read, dc_write, dc_ready;
   logic [ADDR_W-1:0] dc_addr;
   logic [DATA_W-1:0] dc_wdata, dc_rdata;
   logic              mem_read, mem_write, mem_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic [1:0]        grant;

   modport slave (
      input  ic_read, ic_write, ic_addr, ic_wdata,
      input  dc_read, dc_write, dc_addr, dc_wdata,
      input  mem_rdata, mem_ready,
      output ic_rdata, ic_ready, dc_rdata, dc_ready,
      output mem_read, mem_write, mem_addr, mem_wdata, grant
   );

   modport master (
      output ic_read, ic_write, ic_addr, ic_wdata,
      output dc_read, dc_write, dc_addr, dc_wdata,
      output mem_rdata, mem_ready,
      input  ic_rdata, ic_ready, dc_rdata, dc_ready,
      input  mem_read, mem_write, mem_addr, mem_wdata, grant
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin share of one line-wide memory port between I-cache and D-cache.
// One transaction in flight; memory-side outputs are latched at grant and held until mem_ready.
module mem_port_arbiter #(
   parameter int ADDR_W = 28,
   parameter int DATA_W = 128
) (
   input logic                 clk,
   input logic                 rst_n,
   mem_port_arbiter_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, SERV_I, SERV_D} state_e;

   state_e            state_q;
   logic              last_d_q;  // 1: D-cache was granted most recently
   logic              mem_read_q, mem_write_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [1:0]        grant_q;

   logic ic_pend, dc_pend, pick_d;

   assign ic_pend = bus.ic_read | bus.ic_write;
   assign dc_pend = bus.dc_read | bus.dc_write;
   // On a tie, serve whoever did not go last; last starts as I so D wins the first tie.
   assign pick_d  = dc_pend & (~ic_pend | ~last_d_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         last_d_q    <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         grant_q     <= 2'b00;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pick_d) begin
                  state_q     <= SERV_D;
                  last_d_q    <= 1'b1;
                  mem_read_q  <= bus.dc_read & ~bus.dc_write;
                  mem_write_q <= bus.dc_write;
                  mem_addr_q  <= bus.dc_addr;
                  mem_wdata_q <= bus.dc_wdata;
                  grant_q     <= 2'b10;
               end else if (ic_pend) begin
                  state_q     <= SERV_I;
                  last_d_q    <= 1'b0;
                  mem_read_q  <= bus.ic_read & ~bus.ic_write;
                  mem_write_q <= bus.ic_write;
                  mem_addr_q  <= bus.ic_addr;
                  mem_wdata_q <= bus.ic_wdata;
                  grant_q     <= 2'b01;
               end
            end
            SERV_I, SERV_D: begin
               if (bus.mem_ready) begin
                  state_q     <= IDLE;
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  grant_q     <= 2'b00;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_read  = mem_read_q;
   assign bus.mem_write = mem_write_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.grant     = grant_q;

   // Read data is broadcast; only the completion pulse is steered.
   assign bus.ic_rdata  = bus.mem_rdata;
   assign bus.dc_rdata  = bus.mem_rdata;
   assign bus.ic_ready  = (state_q == SERV_I) & bus.mem_ready;
   assign bus.dc_ready  = (state_q == SERV_D) & bus.mem_ready;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] RD_A5 = {16{8'hA5}};
  localparam logic [127:0] WD_D  = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] WD_I  = 128'hCAFE_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] RD_5A = {16{8'h5A}};

  initial begin
    bus.ic_read = 0; bus.ic_write = 0; bus.ic_addr = '0; bus.ic_wdata = '0;
    bus.dc_read = 0; bus.dc_write = 0; bus.dc_addr = '0; bus.dc_wdata = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;

    // reset state
    repeat (2) tick();
    chk("rst_grant", 128'(bus.grant), 128'(0));
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'(0));
    rst_n = 1'b1;
    tick();

    // async reset mid SERV_D
    bus.dc_read = 1; bus.dc_addr = 28'h0000700;
    tick();
    chk("sd_grant", 128'(bus.grant), 128'(2'b10));
    chk("sd_mem_read", 128'(bus.mem_read), 128'(1));
    bus.mem_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_read", 128'(bus.mem_read), 128'(0));
    chk("arst_dc_ready", 128'(bus.dc_ready), 128'(0));
    chk("arst_ic_ready", 128'(bus.ic_ready), 128'(0));
    chk("arst_grant", 128'(bus.grant), 128'(0));
    bus.mem_ready = 0; bus.dc_read = 0;
    tick();
    rst_n = 1'b1;
    tick();

    // single I read, memory answers 3 cycles after strobe
    bus.ic_read = 1; bus.ic_addr = 28'h0000010;
    tick();
    chk("i1_mem_read", 128'(bus.mem_read), 128'(1));
    chk("i1_mem_addr", 128'(bus.mem_addr), 128'(28'h0000010));
    chk("i1_grant", 128'(bus.grant), 128'(2'b01));
    tick(); tick();
    chk("i1_hold_read", 128'(bus.mem_read), 128'(1));
    chk("i1_no_ready", 128'(bus.ic_ready), 128'(0));
    bus.mem_ready = 1; bus.mem_rdata = RD_A5;
    #1;
    chk("i1_ic_ready", 128'(bus.ic_ready), 128'(1));
    chk("i1_ic_rdata", bus.ic_rdata, RD_A5);
    chk("i1_dc_ready", 128'(bus.dc_ready), 128'(0));
    bus.ic_read = 0;
    tick();
    bus.mem_ready = 0;
    #1;
    chk("i1_ready_once", 128'(bus.ic_ready), 128'(0));
    chk("i1_idle_read", 128'(bus.mem_read), 128'(0));
    chk("i1_idle_grant", 128'(bus.grant), 128'(0));

    // simultaneous requests after reset: D first
    rst_n = 1'b0; #1 rst_n = 1'b1;
    tick();
    bus.ic_read = 1; bus.ic_addr = 28'h0000010;
    bus.dc_write = 1; bus.dc_addr = 28'h0000200; bus.dc_wdata = WD_D;
    tick();
    chk("sim_grant_d", 128'(bus.grant), 128'(2'b10));
    chk("sim_mem_write", 128'(bus.mem_write), 128'(1));
    chk("sim_mem_read0", 128'(bus.mem_read), 128'(0));
    chk("sim_mem_addr", 128'(bus.mem_addr), 128'(28'h0000200));
    chk("sim_mem_wdata", bus.mem_wdata, WD_D);
    bus.mem_ready = 1;
    #1;
    chk("sim_dc_ready", 128'(bus.dc_ready), 128'(1));
    chk("sim_ic_ready0", 128'(bus.ic_ready), 128'(0));
    bus.dc_write = 0;
    tick();
    bus.mem_ready = 0;
    chk("sim_gap", 128'({bus.mem_read, bus.mem_write}), 128'(0));
    tick();
    chk("sim_grant_i", 128'(bus.grant), 128'(2'b01));
    chk("sim_i_read", 128'(bus.mem_read), 128'(1));
    chk("sim_i_addr", 128'(bus.mem_addr), 128'(28'h0000010));
    bus.mem_ready = 1; bus.mem_rdata = RD_5A;
    #1;
    chk("sim_i_ready", 128'(bus.ic_ready), 128'(1));
    bus.ic_read = 0;
    tick();
    bus.mem_ready = 0;

    // round-robin, both pending continuously; last grant was I
    bus.ic_read = 1; bus.ic_addr = 28'h0000111;
    bus.dc_read = 1; bus.dc_addr = 28'h0000222;
    for (int k = 0; k < 4; k++) begin
      logic [1:0]        eg;
      logic [ADDR_W-1:0] ea;
      eg = (k % 2 == 0) ? 2'b10 : 2'b01;
      ea = (k % 2 == 0) ? 28'h0000222 : 28'h0000111;
      tick();
      chk($sformatf("rr%0d_grant", k), 128'(bus.grant), 128'(eg));
      chk($sformatf("rr%0d_addr", k), 128'(bus.mem_addr), 128'(ea));
      bus.mem_ready = 1;
      if (k == 3) begin bus.ic_read = 0; bus.dc_read = 0; end
      tick();
      bus.mem_ready = 0;
      chk($sformatf("rr%0d_gap", k), 128'({bus.mem_read, bus.mem_write}), 128'(0));
    end

    // write-back then allocate
    bus.dc_write = 1; bus.dc_addr = 28'h0000300; bus.dc_wdata = WD_D;
    tick();
    chk("wb_mem_write", 128'(bus.mem_write), 128'(1));
    bus.mem_ready = 1;
    #1;
    chk("wb_dc_ready", 128'(bus.dc_ready), 128'(1));
    bus.dc_write = 0;
    tick();
    bus.mem_ready = 0;
    bus.dc_read = 1; bus.dc_addr = 28'h0000400;
    #1;
    chk("wb_r1_no_strobe", 128'(bus.mem_read), 128'(0));
    tick();
    chk("wb_r2_read", 128'(bus.mem_read), 128'(1));
    chk("wb_r2_addr", 128'(bus.mem_addr), 128'(28'h0000400));
    bus.mem_ready = 1;
    #1;
    bus.dc_read = 0;
    tick();
    bus.mem_ready = 0;

    // mem_ready while idle is ignored
    tick();
    bus.mem_ready = 1;
    #1;
    chk("idle_ic_ready", 128'(bus.ic_ready), 128'(0));
    chk("idle_dc_ready", 128'(bus.dc_ready), 128'(0));
    tick();
    bus.mem_ready = 0;
    chk("idle_grant", 128'(bus.grant), 128'(0));

    // read+write together is a write; dropping mid-service does not cancel
    bus.ic_read = 1; bus.ic_write = 1; bus.ic_addr = 28'h0000500; bus.ic_wdata = WD_I;
    tick();
    chk("rw_mem_write", 128'(bus.mem_write), 128'(1));
    chk("rw_mem_read", 128'(bus.mem_read), 128'(0));
    chk("rw_wdata", bus.mem_wdata, WD_I);
    chk("rw_grant", 128'(bus.grant), 128'(2'b01));
    bus.ic_read = 0; bus.ic_write = 0; bus.ic_addr = '0; bus.ic_wdata = '0;
    tick();
    chk("drop_hold_write", 128'(bus.mem_write), 128'(1));
    chk("drop_hold_addr", 128'(bus.mem_addr), 128'(28'h0000500));
    bus.mem_ready = 1;
    #1;
    chk("drop_ic_ready", 128'(bus.ic_ready), 128'(1));
    tick();
    bus.mem_ready = 0;
    chk("drop_idle", 128'(bus.grant), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
